// File: rtl/fsm_updown_counter_mod_if.sv
// Control/status bundle for fsm_updown_counter_mod: the master drives enable, load and mode,
// the slave (the counter) returns count, terminal-count pulse, direction and FSM state.
interface fsm_updown_counter_mod_if #(
  parameter int unsigned NBIT = 8
);
  logic            en;
  logic            load;
  logic [NBIT-1:0] load_val;
  logic [1:0]      mode;
  logic [NBIT-1:0] q;
  logic            tc;
  logic            dir;
  logic [1:0]      state;

  modport master (
    output en, load, load_val, mode,
    input  q, tc, dir, state
  );

  modport slave (
    input  en, load, load_val, mode,
    output q, tc, dir, state
  );
endinterface

// File: rtl/fsm_updown_counter_mod.sv
// Up/down/bounce counter with programmable modulus, parallel load and terminal-count pulse.
// Define FSM_CNT_SAT_EN to saturate at the limits in plain up/down modes instead of wrapping.
module fsm_updown_counter_mod #(
  parameter int unsigned NBIT    = 8,
  parameter int unsigned MAX_VAL = 2**NBIT - 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  fsm_updown_counter_mod_if.slave    bus_io
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StUp   = 2'b01,
    StDown = 2'b10,
    StHold = 2'b11
  } state_e;

  localparam logic [NBIT-1:0] MaxVal = MAX_VAL[NBIT-1:0];
`ifdef FSM_CNT_SAT_EN
  localparam logic [NBIT-1:0] WrapUp   = MaxVal;
  localparam logic [NBIT-1:0] WrapDown = '0;
`else
  localparam logic [NBIT-1:0] WrapUp   = '0;
  localparam logic [NBIT-1:0] WrapDown = MaxVal;
`endif

  state_e          state_q, state_d;
  logic [NBIT-1:0] q_q, q_d;
  logic            tc_q, tc_d;
  logic            dir_q, dir_d;
  logic            bounce;

  assign bounce = (bus_io.mode == 2'b11);

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    tc_d    = 1'b0;
    if (bus_io.load) begin
      q_d = (bus_io.load_val > MaxVal) ? MaxVal : bus_io.load_val;
    end else if (bus_io.en) begin
      case (bus_io.mode)
        2'b00:   state_d = StHold;
        2'b01:   state_d = StUp;
        2'b10:   state_d = StDown;
        default: begin
          case (state_q)
            StUp:    state_d = (q_q == MaxVal) ? StDown : StUp;
            StDown:  state_d = (q_q == '0) ? StUp : StDown;
            default: state_d = StUp;
          endcase
        end
      endcase
      // Count follows the state held before this edge; the new state acts next cycle.
      case (state_q)
        StUp: begin
          if (q_q < MaxVal) begin
            q_d = q_q + NBIT'(1);
          end else begin
            tc_d = 1'b1;
            q_d  = bounce ? (MaxVal - NBIT'(1)) : WrapUp;
          end
        end
        StDown: begin
          if (q_q > '0) begin
            q_d = q_q - NBIT'(1);
          end else begin
            tc_d = 1'b1;
            q_d  = bounce ? NBIT'(1) : WrapDown;
          end
        end
        StIdle, StHold: ;
        default: state_d = StIdle;
      endcase
    end
  end

  assign dir_d = (state_d == StDown);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      q_q     <= '0;
      tc_q    <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      tc_q    <= tc_d;
      dir_q   <= dir_d;
    end
  end

  assign bus_io.q     = q_q;
  assign bus_io.tc    = tc_q;
  assign bus_io.dir   = dir_q;
  assign bus_io.state = state_q;

endmodule
